cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Parametrised run controller for the OoO CPU.
//  - Sequences a stretched core reset.
//  - Counts cycles and retired instructions while the core runs.
//  - Ends the run on halt, global timeout, or retire stall (watchdog), with sticky status flags.
//  - Sits between the top-level clock/reset and the CPU core; the bench and sim top read its status.
// PARAMETERS
//  RST_CYCLES   4    cycles core_rst is held high after rst deasserts (>=1)
//  MAX_CYCLES   40   run-cycle budget; reaching it ends the run with timeout
//  STALL_LIMIT  16   consecutive RUN cycles with zero retires that raise stall_err
//  NUM_RETIRE   2    retire-port count (retire_valid width)
//  CNT_W        16   width of cycle_cnt / retire_cnt
// PORTS
//  clk           in   1            single clock, rising edge
//  rst           in   1            synchronous, active-high reset
//  start         in   1            begin a run (sampled in IDLE)
//  retire_valid  in   NUM_RETIRE   per-port retire strobe from ROB commit
//  halt_req      in   1            core signals end of program (e.g. ecall/halt commit)
//  core_rst      out  1            reset to CPU core, active-high
//  running       out  1            1 while in RUN
//  cycle_cnt     out  CNT_W        cycles spent in RUN
//  retire_cnt    out  CNT_W        total instructions retired in RUN
//  done          out  1            sticky: run ended by halt_req
//  timeout       out  1            sticky: run ended by MAX_CYCLES
//  stall_err     out  1            sticky: run ended by STALL_LIMIT
// BEHAVIOUR
//  Reset (rst=1 at edge): state=HOLD, core_rst=1, running=0.
//    All counters and flags cleared; the rst-cycle load sets hold_cnt so HOLD lasts
//    RST_CYCLES cycles after rst drops.
//    rst asserted in any state, including mid-RUN, aborts to this condition next edge.
//  States: HOLD -> IDLE -> RUN -> {DONE, TOUT, STALL}; all terminal states are absorbing until rst.
//  HOLD: core_rst=1; hold_cnt decrements each cycle.
//    At 0: core_rst=0 and state=IDLE at the same edge.
//  IDLE: core_rst=0. start=1 -> RUN next cycle. Counters stay 0.
//  RUN: running=1. Each cycle:
//    - cycle_cnt += 1
//    - retire_cnt += popcount(retire_valid)
//    - stall_cnt = (retire_valid==0) ? stall_cnt+1 : 0
//  Counters saturate at 2^CNT_W-1 and do not wrap. Width of the popcount sum is clog2(NUM_RETIRE+1).
//  Exit checks use next-state values; priority halt_req > timeout > stall:
//    - halt_req=1                        -> DONE; done=1
//    - else cycle_cnt_next==MAX_CYCLES   -> TOUT; timeout=1
//    - else stall_cnt_next==STALL_LIMIT  -> STALL; stall_err=1
//  The exit cycle's retires are counted. On exit: running=0 next cycle; counters freeze.
//  retire_valid/halt_req are ignored outside RUN. start is ignored outside IDLE.
//  Exactly one of done/timeout/stall_err is ever set per run.
//  All outputs registered; no combinational in->out paths.
// STRUCTURE
//  Package cpu_run_pkg:
//    - state enum encoding (HOLD, IDLE, RUN, DONE, TOUT, STALL)
//    - localparam widths: HOLD_W=clog2(RST_CYCLES+1), STALL_W=clog2(STALL_LIMIT+1)
//  One sub-module: sat_counter (parametrised width, enable, increment amount, sync clear, saturate).
//    Instanced for cycle_cnt, retire_cnt and stall_cnt.
//  Popcount is an inline function; FSM and flags live in the top.
// TESTING (clk period 10 ns; defaults unless stated)
//  1 rst high 2 cycles, then low -> core_rst stays 1 exactly 4 cycles, then 0; state IDLE; all flags 0.
//  2 start, retire_valid=2'b11 every cycle, halt_req pulsed on run cycle 10
//      -> done=1, cycle_cnt=10, retire_cnt=20, running=0 next cycle.
//  3 start, retire_valid=2'b01 always, no halt -> timeout=1 at cycle_cnt=40, retire_cnt=40.
//  4 start, retire_valid=0 always -> stall_err=1 with cycle_cnt=16, retire_cnt=0.
//  5 halt_req and cycle 40 coincide -> done=1, timeout=0.
//    Stall limit and cycle 40 coincide (STALL_LIMIT=40) -> timeout=1, stall_err=0.
//  6 rst asserted at run cycle 7 -> next edge: running=0, counters 0, core_rst=1; HOLD repeats 4 cycles.
//    CNT_W=4, MAX_CYCLES=100 -> cycle_cnt saturates at 15.

Source files
------------

// File: rtl/cpu_run_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_run_pkg
//  Description : State encoding, default sizes and width helper for cpu_run_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_run_pkg;

    typedef logic [2:0] run_state_t;

    localparam run_state_t ST_HOLD  = 3'd0;
    localparam run_state_t ST_IDLE  = 3'd1;
    localparam run_state_t ST_RUN   = 3'd2;
    localparam run_state_t ST_DONE  = 3'd3;
    localparam run_state_t ST_TOUT  = 3'd4;
    localparam run_state_t ST_STALL = 3'd5;

    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_MAX_CYCLES  = 40;
    localparam int DEF_STALL_LIMIT = 16;
    localparam int DEF_NUM_RETIRE  = 2;
    localparam int DEF_CNT_W       = 16;

    // Bits needed to hold the value n itself (not n-1).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int HOLD_W  = cnt_width(DEF_RST_CYCLES);
    localparam int STALL_W = cnt_width(DEF_STALL_LIMIT);

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : cpu_run_ctrl_if
//  Description : Control/status bundle between run controller and core/bench.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_run_ctrl_if #(
    parameter int NUM_RETIRE = 2,
    parameter int CNT_W      = 16
);
    logic                  start;
    logic [NUM_RETIRE-1:0] retire_valid;
    logic                  halt_req;
    logic                  core_rst;
    logic                  running;
    logic [CNT_W-1:0]      cycle_cnt;
    logic [CNT_W-1:0]      retire_cnt;
    logic                  done;
    logic                  timeout;
    logic                  stall_err;

    modport master (
        output start, retire_valid, halt_req,
        input  core_rst, running, cycle_cnt, retire_cnt, done, timeout, stall_err
    );

    modport slave (
        input  start, retire_valid, halt_req,
        output core_rst, running, cycle_cnt, retire_cnt, done, timeout, stall_err
    );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with enable, variable increment, sync clear.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic [INC_W-1:0] inc,
    output logic      [W-1:0]     q
);
    // One spare bit above the wider operand so the carry out is visible.
    localparam int                 c_SUM_W = ((W > INC_W) ? W : INC_W) + 1;
    localparam logic [c_SUM_W-1:0] c_MAX   = c_SUM_W'({W{1'b1}});

    logic [W-1:0]       r_q;
    logic [W-1:0]       w_q_nxt;
    logic [c_SUM_W-1:0] w_sum;

    always_comb begin
        w_sum   = c_SUM_W'(r_q) + c_SUM_W'(inc);
        w_q_nxt = r_q;
        if (clr) begin
            w_q_nxt = '0;
        end else if (en) begin
            w_q_nxt = (w_sum > c_MAX) ? {W{1'b1}} : w_sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_ctrl
//  Description : Stretched core reset, run counters and halt/timeout/stall exit.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int NUM_RETIRE  = DEF_NUM_RETIRE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cpu_run_ctrl_if.slave bus
);
    localparam int c_HOLD_W  = cnt_width(RST_CYCLES);
    localparam int c_STALL_W = cnt_width(STALL_LIMIT);
    localparam int c_PC_W    = cnt_width(NUM_RETIRE);

    function automatic logic [c_PC_W-1:0] popcount(input logic [NUM_RETIRE-1:0] v);
        logic [c_PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_RETIRE; i++) begin
            n = n + c_PC_W'(v[i]);
        end
        return n;
    endfunction

    run_state_t            r_state;
    run_state_t            w_state_nxt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_HOLD_W-1:0]   w_hold_nxt;

    logic                  r_core_rst;
    logic                  r_running;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_stall_err;
    logic                  w_core_rst_nxt;
    logic                  w_running_nxt;
    logic                  w_done_nxt;
    logic                  w_timeout_nxt;
    logic                  w_stall_err_nxt;

    logic                  w_in_run;
    logic                  w_any_retire;
    logic                  w_stall_clr;
    logic [c_PC_W-1:0]     w_retired;
    logic [CNT_W-1:0]      w_cycle_cnt;
    logic [CNT_W-1:0]      w_retire_cnt;
    logic [c_STALL_W-1:0]  w_stall_cnt;
    logic                  w_tout_hit;
    logic                  w_stall_hit;

    assign w_in_run     = (r_state == ST_RUN);
    assign w_any_retire = |bus.retire_valid;
    assign w_retired    = popcount(bus.retire_valid);
    assign w_stall_clr  = w_in_run && w_any_retire;

    sat_counter #(.W(CNT_W), .INC_W(1)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (w_in_run),
        .inc (1'b1),
        .q   (w_cycle_cnt)
    );

    sat_counter #(.W(CNT_W), .INC_W(c_PC_W)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (w_in_run),
        .inc (w_retired),
        .q   (w_retire_cnt)
    );

    sat_counter #(.W(c_STALL_W), .INC_W(1)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_stall_clr),
        .en  (w_in_run),
        .inc (1'b1),
        .q   (w_stall_cnt)
    );

    // Exit compares use the post-increment value; a saturated cycle counter
    // never advances, so it can never newly reach the budget.
    assign w_tout_hit  = (w_cycle_cnt != {CNT_W{1'b1}}) &&
                         ((32'(w_cycle_cnt) + 1) == MAX_CYCLES);
    assign w_stall_hit = !w_any_retire &&
                         ((32'(w_stall_cnt) + 1) == STALL_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= c_HOLD_W'(RST_CYCLES);
            r_core_rst  <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_stall_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_core_rst  <= w_core_rst_nxt;
            r_running   <= w_running_nxt;
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
            r_stall_err <= w_stall_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt <= c_HOLD_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold_cnt - c_HOLD_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    w_state_nxt = ST_DONE;
                end else if (w_tout_hit) begin
                    w_state_nxt = ST_TOUT;
                end else if (w_stall_hit) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_DONE, ST_TOUT, ST_STALL: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    // Terminal states are absorbing, so each flag is simply "next state is X".
    always_comb begin
        w_core_rst_nxt  = (w_state_nxt == ST_HOLD);
        w_running_nxt   = (w_state_nxt == ST_RUN);
        w_done_nxt      = (w_state_nxt == ST_DONE);
        w_timeout_nxt   = (w_state_nxt == ST_TOUT);
        w_stall_err_nxt = (w_state_nxt == ST_STALL);
    end

    assign bus.core_rst   = r_core_rst;
    assign bus.running    = r_running;
    assign bus.cycle_cnt  = w_cycle_cnt;
    assign bus.retire_cnt = w_retire_cnt;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.stall_err  = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_run_ctrl
//  Description : Directed self-checking bench for cpu_run_ctrl (three configs).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_run_ctrl;

    logic clk;
    logic rst_m;
    logic rst_s;
    logic rst_c;
    int   checks;
    int   failures;

    cpu_run_ctrl_if #(.NUM_RETIRE(2), .CNT_W(16)) m   ();
    cpu_run_ctrl_if #(.NUM_RETIRE(2), .CNT_W(16)) s40 ();
    cpu_run_ctrl_if #(.NUM_RETIRE(2), .CNT_W(4))  c4  ();

    cpu_run_ctrl u_dut (.clk(clk), .rst(rst_m), .bus(m));

    cpu_run_ctrl #(.STALL_LIMIT(40)) u_dut_s40 (.clk(clk), .rst(rst_s), .bus(s40));

    cpu_run_ctrl #(.CNT_W(4), .MAX_CYCLES(100)) u_dut_c4 (.clk(clk), .rst(rst_c), .bus(c4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_main();
        rst_m = 1'b1;
        tick();
        rst_m = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_m = 1'b1; rst_s = 1'b1; rst_c = 1'b1;
        tick();
        tick();
        checks++; if (m.core_rst !== 1'b1) begin failures++; $display("FAIL rst_core_rst got=%0d exp=1", m.core_rst); end
        checks++; if (m.running !== 1'b0) begin failures++; $display("FAIL rst_running got=%0d exp=0", m.running); end
        checks++; if (m.cycle_cnt !== 16'd0) begin failures++; $display("FAIL rst_cycle_cnt got=%0d exp=0", m.cycle_cnt); end
        checks++; if (m.retire_cnt !== 16'd0) begin failures++; $display("FAIL rst_retire_cnt got=%0d exp=0", m.retire_cnt); end
        checks++; if ({m.done, m.timeout, m.stall_err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {m.done, m.timeout, m.stall_err}); end
        rst_m = 1'b0; rst_s = 1'b0; rst_c = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (m.core_rst !== (i < 4)) begin
                failures++;
                $display("FAIL hold_core_rst cycle=%0d got=%0d exp=%0d", i, m.core_rst, (i < 4));
            end
        end
        checks++; if (m.running !== 1'b0) begin failures++; $display("FAIL idle_running got=%0d exp=0", m.running); end
        checks++; if (s40.core_rst !== 1'b0 || c4.core_rst !== 1'b0) begin failures++; $display("FAIL other_core_rst got=%0d%0d exp=00", s40.core_rst, c4.core_rst); end
    endtask

    task automatic test_idle_ignore();
        m.retire_valid = 2'b11;
        m.halt_req     = 1'b1;
        repeat (3) tick();
        checks++; if (m.running !== 1'b0) begin failures++; $display("FAIL idle_ign_running got=%0d exp=0", m.running); end
        checks++; if (m.retire_cnt !== 16'd0) begin failures++; $display("FAIL idle_ign_retire got=%0d exp=0", m.retire_cnt); end
        checks++; if (m.done !== 1'b0) begin failures++; $display("FAIL idle_ign_done got=%0d exp=0", m.done); end
        m.retire_valid = 2'b00;
        m.halt_req     = 1'b0;
    endtask

    task automatic test_halt();
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        checks++; if (m.running !== 1'b1) begin failures++; $display("FAIL halt_start_running got=%0d exp=1", m.running); end
        m.retire_valid = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            m.halt_req = (k == 10);
            tick();
            if (k == 9) begin
                checks++; if (m.running !== 1'b1) begin failures++; $display("FAIL halt_c9_running got=%0d exp=1", m.running); end
            end
        end
        m.halt_req = 1'b0;
        checks++; if (m.done !== 1'b1) begin failures++; $display("FAIL halt_done got=%0d exp=1", m.done); end
        checks++; if (m.cycle_cnt !== 16'd10) begin failures++; $display("FAIL halt_cycle_cnt got=%0d exp=10", m.cycle_cnt); end
        checks++; if (m.retire_cnt !== 16'd20) begin failures++; $display("FAIL halt_retire_cnt got=%0d exp=20", m.retire_cnt); end
        checks++; if (m.running !== 1'b0) begin failures++; $display("FAIL halt_running got=%0d exp=0", m.running); end
        checks++; if ({m.timeout, m.stall_err} !== 2'b00) begin failures++; $display("FAIL halt_other_flags got=%b exp=00", {m.timeout, m.stall_err}); end
        repeat (3) tick();
        checks++; if (m.cycle_cnt !== 16'd10 || m.retire_cnt !== 16'd20) begin failures++; $display("FAIL halt_frozen got=%0d/%0d exp=10/20", m.cycle_cnt, m.retire_cnt); end
        checks++; if (m.done !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%0d exp=1", m.done); end
        m.retire_valid = 2'b00;
    endtask

    task automatic test_timeout();
        reset_main();
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        m.retire_valid = 2'b01;
        repeat (39) tick();
        checks++; if (m.running !== 1'b1 || m.timeout !== 1'b0) begin failures++; $display("FAIL tout_c39 got=run%0d/tout%0d exp=run1/tout0", m.running, m.timeout); end
        tick();
        checks++; if (m.timeout !== 1'b1) begin failures++; $display("FAIL tout_flag got=%0d exp=1", m.timeout); end
        checks++; if (m.cycle_cnt !== 16'd40) begin failures++; $display("FAIL tout_cycle_cnt got=%0d exp=40", m.cycle_cnt); end
        checks++; if (m.retire_cnt !== 16'd40) begin failures++; $display("FAIL tout_retire_cnt got=%0d exp=40", m.retire_cnt); end
        checks++; if ({m.running, m.done, m.stall_err} !== 3'b000) begin failures++; $display("FAIL tout_others got=%b exp=000", {m.running, m.done, m.stall_err}); end
        m.retire_valid = 2'b00;
    endtask

    task automatic test_stall();
        reset_main();
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        m.retire_valid = 2'b00;
        repeat (15) tick();
        checks++; if (m.stall_err !== 1'b0 || m.running !== 1'b1) begin failures++; $display("FAIL stall_c15 got=stall%0d/run%0d exp=stall0/run1", m.stall_err, m.running); end
        tick();
        checks++; if (m.stall_err !== 1'b1) begin failures++; $display("FAIL stall_flag got=%0d exp=1", m.stall_err); end
        checks++; if (m.cycle_cnt !== 16'd16) begin failures++; $display("FAIL stall_cycle_cnt got=%0d exp=16", m.cycle_cnt); end
        checks++; if (m.retire_cnt !== 16'd0) begin failures++; $display("FAIL stall_retire_cnt got=%0d exp=0", m.retire_cnt); end
        checks++; if ({m.running, m.done, m.timeout} !== 3'b000) begin failures++; $display("FAIL stall_others got=%b exp=000", {m.running, m.done, m.timeout}); end
    endtask

    task automatic test_stall_rearm();
        reset_main();
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        m.retire_valid = 2'b00;
        repeat (10) tick();
        m.retire_valid = 2'b01;
        tick();
        m.retire_valid = 2'b00;
        repeat (15) tick();
        checks++; if (m.stall_err !== 1'b0 || m.cycle_cnt !== 16'd26) begin failures++; $display("FAIL rearm_c26 got=stall%0d/cyc%0d exp=stall0/cyc26", m.stall_err, m.cycle_cnt); end
        tick();
        checks++; if (m.stall_err !== 1'b1) begin failures++; $display("FAIL rearm_flag got=%0d exp=1", m.stall_err); end
        checks++; if (m.cycle_cnt !== 16'd27 || m.retire_cnt !== 16'd1) begin failures++; $display("FAIL rearm_counts got=%0d/%0d exp=27/1", m.cycle_cnt, m.retire_cnt); end
    endtask

    task automatic test_coincide();
        reset_main();
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        m.retire_valid = 2'b01;
        repeat (39) tick();
        m.halt_req = 1'b1;
        tick();
        m.halt_req = 1'b0;
        m.retire_valid = 2'b00;
        checks++; if ({m.done, m.timeout} !== 2'b10) begin failures++; $display("FAIL coin_halt_flags got=%b exp=10", {m.done, m.timeout}); end
        checks++; if (m.cycle_cnt !== 16'd40 || m.retire_cnt !== 16'd40) begin failures++; $display("FAIL coin_halt_counts got=%0d/%0d exp=40/40", m.cycle_cnt, m.retire_cnt); end

        s40.start = 1'b1;
        tick();
        s40.start = 1'b0;
        repeat (39) tick();
        checks++; if (s40.running !== 1'b1) begin failures++; $display("FAIL coin_s40_c39 got=%0d exp=1", s40.running); end
        tick();
        checks++; if ({s40.timeout, s40.stall_err} !== 2'b10) begin failures++; $display("FAIL coin_stall_flags got=%b exp=10", {s40.timeout, s40.stall_err}); end
        checks++; if (s40.cycle_cnt !== 16'd40) begin failures++; $display("FAIL coin_s40_cycle got=%0d exp=40", s40.cycle_cnt); end
    endtask

    task automatic test_rst_mid_run();
        reset_main();
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        m.retire_valid = 2'b11;
        repeat (6) tick();
        checks++; if (m.cycle_cnt !== 16'd6 || m.retire_cnt !== 16'd12) begin failures++; $display("FAIL midrst_pre got=%0d/%0d exp=6/12", m.cycle_cnt, m.retire_cnt); end
        rst_m = 1'b1;
        tick();
        rst_m = 1'b0;
        checks++; if (m.running !== 1'b0 || m.core_rst !== 1'b1) begin failures++; $display("FAIL midrst_ctrl got=run%0d/crst%0d exp=run0/crst1", m.running, m.core_rst); end
        checks++; if (m.cycle_cnt !== 16'd0 || m.retire_cnt !== 16'd0) begin failures++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", m.cycle_cnt, m.retire_cnt); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (m.core_rst !== (i < 4)) begin
                failures++;
                $display("FAIL midrst_hold cycle=%0d got=%0d exp=%0d", i, m.core_rst, (i < 4));
            end
        end
        checks++; if (m.running !== 1'b0 || m.retire_cnt !== 16'd0) begin failures++; $display("FAIL midrst_idle got=run%0d/ret%0d exp=run0/ret0", m.running, m.retire_cnt); end
        m.retire_valid = 2'b00;
    endtask

    task automatic test_saturate();
        c4.start = 1'b1;
        tick();
        c4.start = 1'b0;
        c4.retire_valid = 2'b11;
        repeat (7) tick();
        checks++; if (c4.cycle_cnt !== 4'd7 || c4.retire_cnt !== 4'd14) begin failures++; $display("FAIL sat_c7 got=%0d/%0d exp=7/14", c4.cycle_cnt, c4.retire_cnt); end
        tick();
        checks++; if (c4.retire_cnt !== 4'd15) begin failures++; $display("FAIL sat_retire got=%0d exp=15", c4.retire_cnt); end
        repeat (12) tick();
        checks++; if (c4.cycle_cnt !== 4'd15) begin failures++; $display("FAIL sat_cycle got=%0d exp=15", c4.cycle_cnt); end
        checks++; if (c4.retire_cnt !== 4'd15) begin failures++; $display("FAIL sat_retire_hold got=%0d exp=15", c4.retire_cnt); end
        checks++; if (c4.running !== 1'b1 || c4.timeout !== 1'b0) begin failures++; $display("FAIL sat_running got=run%0d/tout%0d exp=run1/tout0", c4.running, c4.timeout); end
        c4.retire_valid = 2'b00;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_m = 1'b1; rst_s = 1'b1; rst_c = 1'b1;
        m.start = 1'b0;   m.retire_valid = 2'b00;   m.halt_req = 1'b0;
        s40.start = 1'b0; s40.retire_valid = 2'b00; s40.halt_req = 1'b0;
        c4.start = 1'b0;  c4.retire_valid = 2'b00;  c4.halt_req = 1'b0;

        test_reset();
        test_idle_ignore();
        test_halt();
        test_timeout();
        test_stall();
        test_stall_rearm();
        test_coincide();
        test_rst_mid_run();
        test_saturate();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
